// File: rtl/pair_triple_streak_tracker_if.sv
// Bundles the detector-result inputs and the tracker status outputs for pair_triple_streak_tracker.
// The producer side uses modport master; the tracker uses modport slave.
interface pair_triple_streak_tracker_if #(
  parameter int p_nbits = 4
);
  logic               in_val;
  logic               in_det;
  logic               clear;
  logic [p_nbits-1:0] count;
  logic [p_nbits-1:0] streak;
  logic [p_nbits-1:0] max_streak;
  logic               alarm;

  modport master (
    output in_val, in_det, clear,
    input  count, streak, max_streak, alarm
  );

  modport slave (
    input  in_val, in_det, clear,
    output count, streak, max_streak, alarm
  );
endinterface

// File: rtl/pair_triple_streak_tracker.sv
// Tracks the 2-of-3 detector output: saturating detection count, current and longest streak,
// and a sticky alarm that is raised when the current streak reaches p_thresh.
module pair_triple_streak_tracker #(
  parameter int p_nbits  = 4,
  parameter int p_thresh = 3
) (
  input logic clk,
  input logic rst,
  pair_triple_streak_tracker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, ALARM} state_e;

  localparam logic [p_nbits-1:0] cSatMax = '1;
  localparam logic [p_nbits-1:0] cThresh = p_nbits'(p_thresh);

  state_e             state_q, state_d;
  logic [p_nbits-1:0] count_q, count_d;
  logic [p_nbits-1:0] streak_q, streak_d;
  logic [p_nbits-1:0] maxStreak_q, maxStreak_d;
  logic [p_nbits-1:0] countInc, streakInc;

  assign countInc  = (count_q  == cSatMax) ? count_q  : count_q  + 1'b1;
  assign streakInc = (streak_q == cSatMax) ? streak_q : streak_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    streak_d    = streak_q;
    maxStreak_d = maxStreak_q;

    if (bus.clear) begin
      state_d     = IDLE;
      count_d     = '0;
      streak_d    = '0;
      maxStreak_d = '0;
    end else if (bus.in_val) begin
      if (bus.in_det) begin
        count_d     = countInc;
        streak_d    = streakInc;
        maxStreak_d = (streakInc > maxStreak_q) ? streakInc : maxStreak_q;
      end else begin
        streak_d = '0;
      end

      // ALARM is left only through rst/clear, so a broken run never lowers it.
      case (state_q)
        IDLE: begin
          if (bus.in_det) state_d = (streak_d == cThresh) ? ALARM : RUN;
        end
        RUN: begin
          if (!bus.in_det)               state_d = IDLE;
          else if (streak_d == cThresh)  state_d = ALARM;
        end
        ALARM:   state_d = ALARM;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      streak_q    <= '0;
      maxStreak_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      streak_q    <= streak_d;
      maxStreak_q <= maxStreak_d;
    end
  end

  assign bus.count      = count_q;
  assign bus.streak     = streak_q;
  assign bus.max_streak = maxStreak_q;
  assign bus.alarm      = (state_q == ALARM);

endmodule

// File: tb/tb_pair_triple_streak_tracker.sv
// Directed-vector bench for pair_triple_streak_tracker (p_nbits=4, p_thresh=3):
// a table of single-cycle records plus hand-written saturation and priority sequences.
module tb_pair_triple_streak_tracker;

  typedef struct {
    bit       rst;
    bit       clear;
    bit       val;
    bit       det;
    bit [3:0] count;
    bit [3:0] streak;
    bit [3:0] maxStreak;
    bit       alarm;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  pair_triple_streak_tracker_if #(.p_nbits(4)) bus ();

  pair_triple_streak_tracker #(.p_nbits(4), .p_thresh(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the edge happen, and sample 1 ns later.
  task automatic applyStimulus(input bit r, input bit c, input bit v, input bit d);
    rst        = r;
    bus.clear  = c;
    bus.in_val = v;
    bus.in_det = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input bit [3:0] expCount,
                             input bit [3:0] expStreak, input bit [3:0] expMax,
                             input bit expAlarm);
    total++;
    if (bus.count !== expCount) begin
      bad++;
      $display("[TB] FAIL %s count got=%0d want=%0d", name, bus.count, expCount);
    end
    total++;
    if (bus.streak !== expStreak) begin
      bad++;
      $display("[TB] FAIL %s streak got=%0d want=%0d", name, bus.streak, expStreak);
    end
    total++;
    if (bus.max_streak !== expMax) begin
      bad++;
      $display("[TB] FAIL %s max_streak got=%0d want=%0d", name, bus.max_streak, expMax);
    end
    total++;
    if (bus.alarm !== expAlarm) begin
      bad++;
      $display("[TB] FAIL %s alarm got=%0d want=%0d", name, bus.alarm, expAlarm);
    end
  endtask

  vec_t vecs[17];

  initial begin
    int expSat;
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    bus.clear  = 1'b0;
    bus.in_val = 1'b0;
    bus.in_det = 1'b0;

    //            rst clr val det cnt str max alm
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 0, 1, 0, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[4]  = '{0, 0, 1, 1, 1, 1, 1, 0};
    vecs[5]  = '{0, 0, 1, 1, 2, 2, 2, 0};
    vecs[6]  = '{0, 0, 1, 1, 3, 3, 3, 1};
    vecs[7]  = '{0, 0, 1, 0, 3, 0, 3, 1};
    vecs[8]  = '{0, 0, 1, 1, 4, 1, 3, 1};
    vecs[9]  = '{0, 1, 0, 0, 0, 0, 0, 0};
    vecs[10] = '{0, 0, 1, 1, 1, 1, 1, 0};
    vecs[11] = '{0, 0, 0, 1, 1, 1, 1, 0};
    vecs[12] = '{0, 0, 0, 0, 1, 1, 1, 0};
    vecs[13] = '{0, 0, 1, 1, 2, 2, 2, 0};
    vecs[14] = '{0, 0, 1, 0, 2, 0, 2, 0};
    vecs[15] = '{0, 0, 1, 1, 3, 1, 2, 0};
    vecs[16] = '{0, 1, 1, 1, 0, 0, 0, 0};

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].clear, vecs[i].val, vecs[i].det);
      checkOutput($sformatf("vec%0d", i), vecs[i].count, vecs[i].streak,
                  vecs[i].maxStreak, vecs[i].alarm);
    end

    // Saturation: 20 back-to-back detections after a clean start.
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(0, 0, 1, 1);
      expSat = (i > 15) ? 15 : i;
      checkOutput($sformatf("sat%0d", i), 4'(expSat), 4'(expSat), 4'(expSat), i >= 3);
    end
    applyStimulus(0, 0, 1, 0);
    checkOutput("sat_break", 15, 0, 15, 1);

    // rst and clear together while in ALARM, with a det sample also presented.
    applyStimulus(1, 1, 1, 1);
    checkOutput("rst_clear", 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1);
    checkOutput("post_rst1", 1, 1, 1, 0);
    applyStimulus(0, 0, 1, 1);
    checkOutput("post_rst2", 2, 2, 2, 0);
    applyStimulus(0, 0, 1, 1);
    checkOutput("post_rst3", 3, 3, 3, 1);

    // A lone clear mid-ALARM must also return to IDLE.
    applyStimulus(0, 1, 0, 0);
    checkOutput("clear_alarm", 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1);
    checkOutput("post_clear", 1, 1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
